poly_pointwise_mont_ctrl: RTL and testbench

- Sequences a full polynomial pointwise Montgomery multiply for ML-KEM (FIPS 203): c[i] = a[i]*b[i]*R^-1 mod q, with R = 2^16 and q = 3329.
- Reads coefficient pairs from two synchronous RAMs, forms the 32-bit signed product and feeds one internal modular_reduce instance.
- Writes each reduced coefficient to a result RAM, one coefficient per cycle.
- Sits between the polynomial-arithmetic top-level controller and the coefficient memories.

---
 rtl/poly_pointwise_mont_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_poly_pointwise_mont_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_pointwise_mont_ctrl.sv
// -----------------------------------------------------------------------------
// poly_pointwise_mont_ctrl
//
// Pointwise Montgomery multiply of two ML-KEM polynomials:
//   c[i] = a[i] * b[i] * R^-1 mod q,   R = 2^16, q = 3329.
//
// Coefficient pairs are read from two synchronous RAMs (one-cycle read
// latency) through a shared address. Each 32-bit signed product goes through
// one Montgomery reduction and is written to the result RAM. One coefficient
// is processed per cycle, and the read-to-write latency is 3 cycles.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset, overrides everything
//   start_i    : one-cycle start pulse, accepted only when idle
//   busy_o     : run in progress (reading or draining the pipeline)
//   done_o     : one-cycle pulse after the final write
//   rd_en_o    : read enable to RAM A and RAM B
//   rd_addr_o  : shared read address for A and B
//   a_data_i   : signed coefficient from RAM A, valid one cycle after rd_en_o
//   b_data_i   : signed coefficient from RAM B, valid one cycle after rd_en_o
//   wr_en_o    : write enable to RAM C
//   wr_addr_o  : write address to RAM C (holds its value while wr_en_o = 0)
//   wr_data_o  : signed reduced coefficient in (-q, q) (holds while wr_en_o = 0)
// -----------------------------------------------------------------------------
module poly_pointwise_mont_ctrl #(
  parameter int N_COEFFS = 256,
  parameter int ADDR_W   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     rd_en_o,
  output logic [ADDR_W-1:0]        rd_addr_o,
  input  logic signed [15:0]       a_data_i,
  input  logic signed [15:0]       b_data_i,
  output logic                     wr_en_o,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic signed [15:0]       wr_data_o
);

  // ---------------------------------------------------------------------------
  // Constants and parameter sanity
  // ---------------------------------------------------------------------------
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEFFS - 1);

  // q and -q^-1 mod 2^16, which are the Montgomery constants for R = 2^16.
  localparam logic signed [31:0] KYBER_Q    = 32'sd3329;
  localparam logic signed [31:0] KYBER_QNEG = 32'sd3327;

  // The counter relies on N_COEFFS filling the address space exactly.
  if (N_COEFFS < 4 || N_COEFFS != (1 << ADDR_W)) begin : g_param_check
    $error("poly_pointwise_mont_ctrl: N_COEFFS must be a power of two >= 4 and equal 2**ADDR_W");
  end

  // ---------------------------------------------------------------------------
  // Montgomery reduction (combinational)
  //   m = low16(p * (-q^-1)), taken as signed
  //   r = (p + m*q) >>> 16
  // p + m*q is divisible by 2^16 by construction. Treating m as signed keeps
  // |m| <= 2^15. Because |p| < q*2^15, this keeps r within (-q, q). The
  // intermediate sum stays below 2^31 in magnitude, so 32 bits are enough.
  // ---------------------------------------------------------------------------
  function automatic logic signed [15:0] modular_reduce(input logic signed [31:0] p);
    logic signed [15:0] m;
    logic signed [31:0] acc;
    m   = 16'(p * KYBER_QNEG);
    acc = p + (m * KYBER_Q);
    return 16'(acc >>> 16);
  endfunction

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] rd_addr_q;

  // Pipeline valid bits. s1 means the RAM data for s1_addr_q is on the bus.
  // s2 means prod_q holds the product for s2_addr_q.
  logic s1_valid_q, s2_valid_q;
  logic [ADDR_W-1:0] s1_addr_q, s2_addr_q;
  logic signed [31:0] prod_q;
  logic signed [15:0] reduced;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_READ;
      ST_READ:  if (rd_addr_q == LAST_ADDR) state_d = ST_DRAIN;
      // The last write is on the wr_* port in the cycle where both earlier
      // stages are empty. Leaving here puts done_o right after that write.
      ST_DRAIN: if (!s1_valid_q && !s2_valid_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Moore outputs. busy_o drops while in DONE, so busy_o and done_o are
  // never high together.
  always_comb begin
    rd_en_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      ST_IDLE:  ;
      ST_READ: begin
        rd_en_o = 1'b1;
        busy_o  = 1'b1;
      end
      ST_DRAIN: busy_o = 1'b1;
      ST_DONE:  done_o = 1'b1;
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read address counter: cleared on an accepted start, advances every READ
  // cycle and parks on the last address instead of wrapping.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_addr_q <= '0;
    end else if (state_q == ST_IDLE && start_i) begin
      rd_addr_q <= '0;
    end else if (state_q == ST_READ && rd_addr_q != LAST_ADDR) begin
      rd_addr_q <= rd_addr_q + ADDR_W'(1);
    end
  end

  assign rd_addr_o = rd_addr_q;

  // ---------------------------------------------------------------------------
  // Pipeline control: valid bits are reset so an aborted run issues no writes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      wr_en_o    <= 1'b0;
    end else begin
      s1_valid_q <= rd_en_o;
      s2_valid_q <= s1_valid_q;
      wr_en_o    <= s2_valid_q;
    end
  end

  // Pipeline datapath.
  // NOTE: these registers are deliberately left out of reset. Their contents
  // are only observed when the matching valid bit is set, and that bit is
  // reset.
  always_ff @(posedge clk_i) begin
    if (rd_en_o) begin
      s1_addr_q <= rd_addr_q;
    end
    if (s1_valid_q) begin
      // The full 32-bit signed product is kept and is never truncated.
      prod_q    <= a_data_i * b_data_i;
      s2_addr_q <= s1_addr_q;
    end
  end

  assign reduced = modular_reduce(prod_q);

  // The write port is reset, and it holds its last value between writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else if (s2_valid_q) begin
      wr_addr_o <= s2_addr_q;
      wr_data_o <= reduced;
    end
  end

endmodule

// File: tb/tb_poly_pointwise_mont_ctrl.sv
// -----------------------------------------------------------------------------
// tb_poly_pointwise_mont_ctrl
//
// Directed bench for poly_pointwise_mont_ctrl. It models RAM A and RAM B as
// synchronous memories and captures every write into a result image. Timing
// is measured in cycles relative to the cycle in which start_i was accepted.
// -----------------------------------------------------------------------------
module tb_poly_pointwise_mont_ctrl;

  localparam int N      = 256;
  localparam int ADDR_W = 8;
  localparam int Q      = 3329;

  logic                     clk = 1'b0;
  logic                     rst_i;
  logic                     start_i;
  logic                     busy_o;
  logic                     done_o;
  logic                     rd_en_o;
  logic [ADDR_W-1:0]        rd_addr_o;
  logic signed [15:0]       a_data_i;
  logic signed [15:0]       b_data_i;
  logic                     wr_en_o;
  logic [ADDR_W-1:0]        wr_addr_o;
  logic signed [15:0]       wr_data_o;

  poly_pointwise_mont_ctrl #(.N_COEFFS(N), .ADDR_W(ADDR_W)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .rd_en_o   (rd_en_o),
    .rd_addr_o (rd_addr_o),
    .a_data_i  (a_data_i),
    .b_data_i  (b_data_i),
    .wr_en_o   (wr_en_o),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source RAMs with one-cycle read latency.
  logic signed [15:0] mem_a [N];
  logic signed [15:0] mem_b [N];
  initial begin
    a_data_i = '0;
    b_data_i = '0;
  end
  always @(posedge clk) begin
    if (rd_en_o) begin
      a_data_i <= mem_a[rd_addr_o];
      b_data_i <= mem_b[rd_addr_o];
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference Montgomery product.
  function automatic int mont_ref(input int a, input int b);
    int      p;
    shortint m;
    p = a * b;
    m = shortint'(p * 3327);
    return (p + int'(m) * Q) >>> 16;
  endfunction

  // ---------------------------------------------------------------------------
  // Write monitor, sampled on the falling edge
  // ---------------------------------------------------------------------------
  int c0 = 0;
  int rst_at = -1;
  int res [N];
  int wr_count, first_wr, last_wr, gap_err, order_err, late_wr;
  int done_count, done_k, both_err;
  int busy_k0, busy_k1, busy_kn3, busy_kn5, busy_rst;

  always @(negedge clk) begin
    int k;
    k = cyc - c0;
    if (wr_en_o) begin
      res[wr_addr_o] = int'(wr_data_o);
      if (wr_count == 0) first_wr = k;
      else if (k != last_wr + 1) gap_err++;
      if (int'(wr_addr_o) != wr_count) order_err++;
      if (rst_at >= 0 && k > rst_at) late_wr++;
      last_wr = k;
      wr_count++;
    end
    if (done_o) begin
      done_count++;
      done_k = k;
    end
    if (busy_o && done_o) both_err++;
    if (k == 0)     busy_k0  = int'(busy_o);
    if (k == 1)     busy_k1  = int'(busy_o);
    if (k == N + 3) busy_kn3 = int'(busy_o);
    if (k == N + 5) busy_kn5 = int'(busy_o);
    if (rst_at >= 0 && k == rst_at + 2) busy_rst = int'(busy_o);
  end

  task automatic clear_stats();
    for (int i = 0; i < N; i++) res[i] = 99999;
    wr_count = 0; first_wr = -1; last_wr = -1; gap_err = 0; order_err = 0;
    late_wr = 0; done_count = 0; done_k = -1; both_err = 0;
    busy_k0 = -1; busy_k1 = -1; busy_kn3 = -1; busy_kn5 = -1; busy_rst = -1;
  endtask

  // Counts result entries that differ from the reference model.
  function automatic int count_bad();
    int bad = 0;
    for (int i = 0; i < N; i++)
      if (res[i] != mont_ref(int'(mem_a[i]), int'(mem_b[i]))) bad++;
    return bad;
  endfunction

  // Starts a run. Optionally pulses start_i or rst_i at a given relative
  // cycle (-1 means none). The wait is bounded and ends with 10 idle cycles.
  task automatic run(input int extra_at, input int rst_at_in);
    int k;
    @(posedge clk); #1;
    clear_stats();
    rst_at  = rst_at_in;
    c0      = cyc;
    start_i = 1'b1;
    for (int i = 0; i < N + 40; i++) begin
      @(posedge clk); #1;
      k       = cyc - c0;
      start_i = (k == extra_at);
      rst_i   = (k == rst_at);
      if (rst_at < 0 && done_count > 0) break;
      if (rst_at >= 0 && k > rst_at + 3) break;
    end
    start_i = 1'b0;
    rst_i   = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic check_full_run(input string tag);
    check({tag, "_wr_count"},   wr_count,   N);
    check({tag, "_first_wr"},   first_wr,   4);
    check({tag, "_last_wr"},    last_wr,    N + 3);
    check({tag, "_gaps"},       gap_err,    0);
    check({tag, "_order"},      order_err,  0);
    check({tag, "_done_count"}, done_count, 1);
    check({tag, "_done_cycle"}, done_k,     N + 4);
    check({tag, "_busy_k0"},    busy_k0,    0);
    check({tag, "_busy_k1"},    busy_k1,    1);
    check({tag, "_busy_kn3"},   busy_kn3,   1);
    check({tag, "_busy_kn5"},   busy_kn5,   0);
    check({tag, "_busy_done"},  both_err,   0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int bad;
    clear_stats();

    // Reset, with start_i held high throughout.
    rst_i   = 1'b1;
    start_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_i   = 1'b0;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_busy",    int'(busy_o),    0);
    check("rst_done",    int'(done_o),    0);
    check("rst_rd_en",   int'(rd_en_o),   0);
    check("rst_wr_en",   int'(wr_en_o),   0);
    check("rst_rd_addr", int'(rd_addr_o), 0);
    check("rst_wr_addr", int'(wr_addr_o), 0);
    check("rst_wr_data", int'(wr_data_o), 0);
    check("rst_no_wr",   wr_count,        0);
    check("rst_no_done", done_count,      0);

    // All ones: 1*1*R^-1 = 169.
    for (int i = 0; i < N; i++) begin mem_a[i] = 16'sd1; mem_b[i] = 16'sd1; end
    run(-1, -1);
    check_full_run("ones");
    bad = 0;
    for (int i = 0; i < N; i++) if (res[i] != 169) bad++;
    check("ones_all_169", bad, 0);
    check("ones_c0",   res[0],   169);
    check("ones_c255", res[255], 169);

    // a = R mod q, so c[i] is congruent to b[i] = i.
    for (int i = 0; i < N; i++) begin mem_a[i] = 16'sd2285; mem_b[i] = 16'(i); end
    run(-1, -1);
    check_full_run("rmodq");
    check("rmodq_c0", res[0], 0);
    check("rmodq_c1", res[1], 1);
    check("rmodq_c7", res[7], 7);
    bad = 0;
    for (int i = 0; i < N; i++)
      if (res[i] <= -Q || res[i] >= Q || ((res[i] - i) % Q) != 0) bad++;
    check("rmodq_congruent", bad, 0);

    // Random operands, with hand-checked corner entries in slots 0..2.
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 16'(int'($urandom_range(0, 6656)) - 3328);
      mem_b[i] = 16'(int'($urandom_range(0, 6656)) - 3328);
    end
    mem_a[0] = 16'sd3328;  mem_b[0] = 16'sd3328;
    mem_a[1] = -16'sd3328; mem_b[1] = 16'sd3328;
    mem_a[2] = -16'sd1;    mem_b[2] = 16'sd1;
    run(-1, -1);
    check_full_run("rand");
    check("rand_c0_max", res[0], 169);
    check("rand_c1_min", res[1], -169);
    check("rand_c2_neg", res[2], -169);
    check("rand_golden", count_bad(), 0);

    // A start pulse in the middle of a run is ignored.
    run(50, -1);
    check_full_run("midstart");
    check("midstart_golden", count_bad(), 0);

    // Reset at cycle 100 aborts the run. Reads at cycles 1..100 complete as
    // writes at cycles 4..100 only.
    run(-1, 100);
    check("abort_wr_count",  wr_count,       97);
    check("abort_late_wr",   late_wr,        0);
    check("abort_done",      done_count,     0);
    check("abort_busy",      busy_rst,       0);
    check("abort_idle_wr",   int'(wr_en_o),  0);
    check("abort_idle_rd",   int'(rd_en_o),  0);

    // A fresh run after the abort completes correctly.
    rst_at = -1;
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 16'(int'($urandom_range(0, 6656)) - 3328);
      mem_b[i] = 16'(int'($urandom_range(0, 6656)) - 3328);
    end
    run(-1, -1);
    check_full_run("rerun");
    check("rerun_golden", count_bad(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
